// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses 'I'/'D' blocks of little-endian words into
// the instruction/data BRAM write ports, then releases the CPU on 'G'.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  cpu_run,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  state_t                state_q, state_d;
  logic                  tgt_i_q, tgt_i_d;   // 1: instruction BRAM, 0: data BRAM
  logic [15:0]           count_q, count_d;
  logic [15:0]           widx_q, widx_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [DATA_WIDTH-1:0] i_dat_q, i_dat_d, d_dat_q, d_dat_d;
  logic                  accept;
  logic [15:0]           cnt_new;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_i_q  <= 1'b0;
      count_q  <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      i_addr_q <= '0;
      i_dat_q  <= '0;
      d_addr_q <= '0;
      d_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      tgt_i_q  <= tgt_i_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      i_addr_q <= i_addr_d;
      i_dat_q  <= i_dat_d;
      d_addr_q <= d_addr_d;
      d_dat_q  <= d_dat_d;
    end
  end

  // Next-state and datapath update; write port address/data are loaded on the
  // 4th byte so they are valid during the single WRITE cycle and hold after it
  always_comb begin
    state_d  = state_q;
    tgt_i_d  = tgt_i_q;
    count_d  = count_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    i_addr_d = i_addr_q;
    i_dat_d  = i_dat_q;
    d_addr_d = d_addr_q;
    d_dat_d  = d_dat_q;
    accept   = in_valid & in_ready;
    cnt_new  = {in_byte, count_q[7:0]};
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_byte)
            8'h49: begin tgt_i_d = 1'b1; state_d = CNT_LO; end
            8'h44: begin tgt_i_d = 1'b0; state_d = CNT_LO; end
            8'h47: state_d = RUN;
            default: state_d = ERR;
          endcase
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_d[7:0] = in_byte;
          state_d      = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_d[15:8] = in_byte;
          if (cnt_new == 16'd0) begin
            state_d = IDLE;
          end else if ({1'b0, cnt_new} > MAX_CNT) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            widx_d  = '0;
            bidx_d  = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{bidx_q, 3'b000} +: 8] = in_byte;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = WRITE;
            if (tgt_i_q) begin
              i_addr_d = ADDR_WIDTH'({widx_q, 2'b00});
              i_dat_d  = word_d;
            end else begin
              d_addr_d = ADDR_WIDTH'({widx_q, 2'b00});
              d_dat_d  = word_d;
            end
          end
        end
      end
      WRITE: begin
        widx_d  = widx_q + 16'd1;
        state_d = (widx_q + 16'd1 == count_q) ? IDLE : DATA;
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready         = (state_q == IDLE) || (state_q == CNT_LO) ||
                       (state_q == CNT_HI) || (state_q == DATA);
    i_w_enb          = (state_q == WRITE) && tgt_i_q;
    d_w_enb          = (state_q == WRITE) && !tgt_i_q;
    cpu_run          = (state_q == RUN);
    d_bram_init_done = (state_q == RUN);
    load_err         = (state_q == ERR);
    i_w_addr         = i_addr_q;
    i_w_dat          = i_dat_q;
    d_w_addr         = d_addr_q;
    d_w_dat          = d_dat_q;
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: byte streams are built from block
// descriptions, and the expected writes/status are derived from that build.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb, d_bram_init_done, cpu_run, load_err;

  boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .d_bram_init_done(d_bram_init_done), .cpu_run(cpu_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    bit          wr;
    bit          tgt;
    logic [9:0]  addr;
    logic [31:0] dat;
    bit          run;
    bit          err;
  } ev_t;

  typedef struct {
    bit          tgt;
    logic [9:0]  addr;
    logic [31:0] dat;
  } wr_t;

  ev_t         stream[$];
  wr_t         expq[$];
  int          dueq[$];
  wr_t         logq[$];
  wr_t         log1[$];
  logic [31:0] wq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nexp = 0;
  bit          chk_en = 1'b0;
  bit          exp_run = 1'b0;
  bit          exp_err = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stream builder ----------------
  function automatic void add_raw(input logic [7:0] b, input bit run, input bit err);
    ev_t e;
    e.b = b; e.wr = 0; e.tgt = 0; e.addr = '0; e.dat = '0; e.run = run; e.err = err;
    stream.push_back(e);
  endfunction

  // One 'I'/'D' block of n words taken from wq (wq is left intact)
  function automatic void add_block(input bit tgt, input int n);
    logic [15:0] n16;
    ev_t e;
    n16 = n[15:0];
    add_raw(tgt ? 8'h49 : 8'h44, 0, 0);
    add_raw(n16[7:0], 0, 0);
    add_raw(n16[15:8], 0, (n > 256));
    if (n == 0 || n > 256) return;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        e.b    = wq[i][8*k +: 8];
        e.wr   = (k == 3);
        e.tgt  = tgt;
        e.addr = 10'(i * 4);
        e.dat  = wq[i];
        e.run  = 0;
        e.err  = 0;
        stream.push_back(e);
      end
      nexp++;
    end
  endfunction

  function automatic void fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endfunction

  // ---------------- driver ----------------
  task automatic send(input ev_t ev, input int gap_pct);
    int t;
    @(negedge clk);
    t = 0;
    while ($urandom_range(99) < gap_pct && t < 10) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(negedge clk);
      t++;
    end
    in_byte  = ev.b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready stayed %b, needed 1 (t=%0t)", in_ready, $time);
      in_valid = 1'b0;
      return;
    end
    if (ev.wr) begin
      wr_t w;
      w.tgt = ev.tgt; w.addr = ev.addr; w.dat = ev.dat;
      expq.push_back(w);
      dueq.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    exp_run = exp_run | ev.run;
    exp_err = exp_err | ev.err;
  endtask

  task automatic run_stream(input int gap_pct);
    ev_t ev;
    while (stream.size() > 0) begin
      ev = stream.pop_front();
      send(ev, gap_pct);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en   = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_enb", {i_w_enb, d_w_enb}, 0);
    chk("rst_status", {cpu_run, d_bram_init_done, load_err}, 0);
    chk("rst_addr", {i_w_addr, d_w_addr}, 0);
    chk("rst_i_dat", i_w_dat, 0);
    chk("rst_d_dat", d_w_dat, 0);
    stream.delete(); expq.delete(); dueq.delete(); logq.delete();
    exp_run = 0; exp_err = 0; nexp = 0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit  due;
      wr_t w, a;
      due = (dueq.size() > 0) && (dueq[0] == cyc);
      chk("enb_timing", i_w_enb | d_w_enb, due);
      chk("enb_exclusive", i_w_enb & d_w_enb, 0);
      if (i_w_enb | d_w_enb) begin
        a.tgt  = i_w_enb;
        a.addr = i_w_enb ? i_w_addr : d_w_addr;
        a.dat  = i_w_enb ? i_w_dat : d_w_dat;
        logq.push_back(a);
      end
      if (due) begin
        void'(dueq.pop_front());
        w = expq.pop_front();
        chk("wr_target", i_w_enb, w.tgt);
        chk("wr_addr", w.tgt ? i_w_addr : d_w_addr, w.addr);
        chk("wr_data", w.tgt ? i_w_dat : d_w_dat, w.dat);
      end
      chk("cpu_run", cpu_run, exp_run);
      chk("init_done", d_bram_init_done, exp_run);
      chk("load_err", load_err, exp_err);
      if (exp_run | exp_err) chk("ready_off", in_ready, 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int nb, n, pick;
    logic [7:0] bb;
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    do_reset();

    // Instruction block of two known words
    wq = '{32'h00500513, 32'h00100593};
    add_block(1, 2);
    run_stream(0);
    idle(3);
    chk("i_blk_count", logq.size(), 2);
    if (logq.size() == 2) begin
      chk("i_blk_w0", {logq[0].tgt, 6'd0, logq[0].addr, logq[0].dat}, {1'b1, 6'd0, 10'h000, 32'h00500513});
      chk("i_blk_w1", {logq[1].tgt, 6'd0, logq[1].addr, logq[1].dat}, {1'b1, 6'd0, 10'h004, 32'h00100593});
    end

    // Data block then 'G'
    logq.delete();
    wq = '{32'h00000001};
    add_block(0, 1);
    add_raw(8'h47, 1, 0);
    run_stream(0);
    chk("go_cpu_run", cpu_run, 1);
    chk("go_init_done", d_bram_init_done, 1);
    chk("go_in_ready", in_ready, 0);
    idle(2);
    chk("d_blk_count", logq.size(), 1);
    if (logq.size() == 1)
      chk("d_blk_w0", {logq[0].tgt, 6'd0, logq[0].addr, logq[0].dat}, {1'b0, 6'd0, 10'h000, 32'h00000001});
    in_valid = 1'b1; in_byte = 8'h49;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("run_sticky", cpu_run, 1);

    // Oversized count goes to ERR
    do_reset();
    add_block(1, 257);
    run_stream(0);
    idle(6);
    chk("big_err", load_err, 1);
    chk("big_ready", in_ready, 0);
    chk("big_nowr", logq.size(), 0);

    // Unknown command, then recovery by reset
    do_reset();
    add_raw(8'h55, 0, 1);
    run_stream(0);
    idle(2);
    chk("badcmd_err", load_err, 1);
    do_reset();
    chk("recov_err", load_err, 0);
    chk("recov_ready", in_ready, 1);

    // Zero-count block is a no-op, then a maximum-size block
    do_reset();
    add_block(1, 0);
    fill_rand(256);
    add_block(0, 256);
    run_stream(0);
    idle(3);
    chk("max_count", logq.size(), 256);
    if (logq.size() == 256) chk("max_last_addr", logq[255].addr, 10'h3FC);

    // Same 4-word data block without and with in_valid gaps
    do_reset();
    fill_rand(4);
    add_block(0, 4);
    run_stream(0);
    idle(2);
    log1 = logq;
    logq.delete();
    add_block(0, 4);
    run_stream(20);
    idle(2);
    chk("gap_count", logq.size(), 4);
    if (logq.size() == 4 && log1.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("gap_addr", logq[i].addr, 10'(4 * i));
        chk("gap_same", logq[i].dat, log1[i].dat);
      end
    end

    // Reset after 2 bytes of the second word, then a fresh 1-word block
    do_reset();
    fill_rand(2);
    add_block(1, 2);
    void'(stream.pop_back());
    void'(stream.pop_back());
    run_stream(0);
    do_reset();
    fill_rand(1);
    add_block(1, 1);
    run_stream(0);
    idle(4);
    chk("rst_mid_count", logq.size(), 1);
    if (logq.size() == 1)
      chk("rst_mid_w", {logq[0].tgt, 6'd0, logq[0].addr, logq[0].dat}, {1'b1, 6'd0, 10'h000, wq[0]});

    // Randomized block sequences
    for (int r = 0; r < 8; r++) begin
      do_reset();
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        n = $urandom_range(0, 6);
        fill_rand(n);
        add_block(1'($urandom_range(1)), n);
      end
      pick = $urandom_range(2);
      if (pick == 0) add_raw(8'h47, 1, 0);
      else if (pick == 1) begin
        do bb = 8'($urandom); while (bb == 8'h49 || bb == 8'h44 || bb == 8'h47);
        add_raw(bb, 0, 1);
      end
      run_stream($urandom_range(0, 25));
      idle(4);
      chk("rand_count", logq.size(), nexp);
    end

    chk("expq_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving the byte address width of each BRAM write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the BRAM word width.
REQ-003 SHALL have parameter MAX_WORDS, default 256, giving the maximum word count per block (2^ADDR_WIDTH / 4).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_byte  input  8  byte from the host stream.
REQ-007 in_valid  input  1  in_byte is valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 i_w_addr  output  ADDR_WIDTH  instruction BRAM write byte address.
REQ-010 i_w_dat  output  DATA_WIDTH  instruction BRAM write data.
REQ-011 i_w_enb  output  1  instruction BRAM write enable.
REQ-012 d_w_addr  output  ADDR_WIDTH  data BRAM write byte address.
REQ-013 d_w_dat  output  DATA_WIDTH  data BRAM write data.
REQ-014 d_w_enb  output  1  data BRAM write enable.
REQ-015 d_bram_init_done  output  1  data BRAM port handed to the CPU datapath.
REQ-016 cpu_run  output  1  CPU released: drives pc_stall low, i_r_enb high and register read enable high.
REQ-017 load_err  output  1  sticky protocol error.

Function
REQ-018 Byte transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1.
REQ-019 FSM states SHALL be IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR.
REQ-020 in_ready SHALL be 1 in IDLE, CNT_LO, CNT_HI and DATA, and 0 in WRITE, RUN and ERR.
REQ-021 IDLE commands: 0x49 ('I') selects the instruction target and goes to CNT_LO; 0x44 ('D') selects the data target and goes to CNT_LO; 0x47 ('G') goes to RUN; any other byte goes to ERR.
REQ-022 CNT_LO SHALL capture count[7:0], and CNT_HI SHALL capture count[15:8] (16-bit little-endian word count).
REQ-023 After CNT_HI: count=0 -> IDLE; count>MAX_WORDS -> ERR; otherwise -> DATA with word index 0 and byte index 0.
REQ-024 DATA SHALL assemble words little-endian: byte k is placed in bits [8k+7:8k].
REQ-025 Acceptance of the 4th byte of a word SHALL move the FSM to WRITE.
REQ-026 WRITE SHALL last exactly one cycle: the selected target's w_enb=1, w_addr=word_index*4 and w_dat=the assembled word; the other target's enable SHALL stay 0.
REQ-027 After WRITE, the word index SHALL increment; the FSM SHALL go to IDLE if word_index+1 == count, else back to DATA.
REQ-028 The write latency SHALL be one cycle from acceptance of the 4th byte to the w_enb pulse.
REQ-029 Both w_enb outputs SHALL be 0 in every state other than WRITE; address and data outputs hold their last value.
REQ-030 The loader SHALL accept multiple 'I'/'D' blocks in any order; each block SHALL restart at address 0.
REQ-031 RUN SHALL be sticky until reset, with cpu_run=1 and d_bram_init_done=1; in_byte is ignored.
REQ-032 ERR SHALL be sticky until reset, with load_err=1, cpu_run=0 and d_bram_init_done=0.
REQ-033 in_valid gaps SHALL stall the FSM with no state change and no partial write.

Reset
REQ-034 Asserting rst SHALL, with no clock edge required, put the FSM in IDLE and drive all outputs to 0 except in_ready, which SHALL be 1.
REQ-035 rst SHALL also clear the count, word index, byte index and assembled word to 0.
REQ-036 rst asserted mid-block SHALL discard the partial word; no w_enb pulse SHALL follow reset.

Verification
REQ-037 Load block: 'I', 0x02, 0x00, bytes 13 05 50 00 93 05 10 00 -> i_w_enb pulses: addr 0x000 data 0x00500513, then addr 0x004 data 0x00100593; d_w_enb stays 0.
REQ-038 Load block: 'D', 0x01, 0x00, 01 00 00 00, then 'G' -> d_w_enb pulse at addr 0x000 with data 0x00000001; the cycle after 'G' is accepted, cpu_run=1, d_bram_init_done=1 and in_ready=0.
REQ-039 Header 'I', 0x01, 0x01 (count 257) -> ERR: load_err=1, in_ready=0, no writes, state held until rst.
REQ-040 Byte 0x55 received in IDLE -> load_err=1; after rst, load_err=0 and the loader is back in IDLE.
REQ-041 Random in_valid gaps (20% duty) during a 4-word 'D' block -> same addresses (0,4,8,C) and data as the gap-free run, with exactly 4 pulses.
REQ-042 rst asserted after 2 bytes of the second word, then a fresh 'I' block of 1 word -> no stray pulse; a single write at addr 0x000 with the new word.
